// File: rtl/instruction_fetch_register.sv
// Multi-byte instruction register fed from a byte-wide memory path.
// Supports manual lane loading and an auto-fetch sequencer with a valid/ack handshake toward the decoder.
module instruction_fetch_register #(
  parameter int BYTE_W    = 8,
  parameter int BYTES     = 2,
  parameter int LSB_FIRST = 1,
  parameter int SEL_W     = $clog2(BYTES)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [BYTE_W-1:0]       i_i,
  input  logic                    i_mode,
  input  logic                    i_write,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic                    i_start,
  input  logic                    i_mem_rdy,
  input  logic                    i_ack,
  input  logic                    i_flush,
  output logic                    o_mem_read,
  output logic                    o_ir_valid,
  output logic                    o_busy,
  output logic [SEL_W:0]          o_byte_cnt,
  output logic [BYTE_W*BYTES-1:0] o_ir_out
);

  localparam int CW = SEL_W + 1;
  localparam logic [SEL_W:0] LAST = CW'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic [SEL_W:0]    r_cnt;
  logic [BYTE_W-1:0] r_lane [BYTES];

  logic             w_man_wr;
  logic             w_cap;
  logic [BYTES-1:0] w_lane_we;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_mode && i_start) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
          end
        end
        S_FETCH: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (i_mem_rdy) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_state <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (i_ack) begin
            // Ack together with Start chains straight into the next fetch.
            r_cnt   <= '0;
            r_state <= (i_start && i_mode) ? S_FETCH : S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_man_wr = (r_state == S_IDLE) && !i_mode && i_write;
  assign w_cap    = (r_state == S_FETCH) && !i_flush && i_mem_rdy;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      // Lane that receives the byte while ByteCnt equals FIDX.
      localparam int FIDX = (LSB_FIRST != 0) ? gi : (BYTES - 1 - gi);

      assign w_lane_we[gi] = (w_man_wr && (int'(i_sel) == gi)) ||
                             (w_cap && (r_cnt == CW'(FIDX)));

      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          r_lane[gi] <= '0;
        end else if (w_lane_we[gi]) begin
          r_lane[gi] <= i_i;
        end
      end

      assign o_ir_out[gi*BYTE_W +: BYTE_W] = r_lane[gi];
    end
  endgenerate

  assign o_mem_read = (r_state == S_FETCH);
  assign o_busy     = (r_state == S_FETCH);
  assign o_ir_valid = (r_state == S_FULL);
  assign o_byte_cnt = r_cnt;

endmodule

// File: tb/tb_instruction_fetch_register.sv
// Directed bench: a 2-byte LSB-first instance (wide select) and a 4-byte MSB-first instance.
module tb_instruction_fetch_register;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: BYTES=2, LSB_FIRST=1, SEL_W widened to 2 so Sel=2 is expressible.
  logic [7:0]  a_i;
  logic        a_mode, a_write, a_start, a_mem_rdy, a_ack, a_flush;
  logic [1:0]  a_sel;
  logic        a_mem_read, a_ir_valid, a_busy;
  logic [2:0]  a_cnt;
  logic [15:0] a_ir;

  // Instance B: BYTES=4, LSB_FIRST=0.
  logic [7:0]  b_i;
  logic        b_mode, b_write, b_start, b_mem_rdy, b_ack, b_flush;
  logic [1:0]  b_sel;
  logic        b_mem_read, b_ir_valid, b_busy;
  logic [2:0]  b_cnt;
  logic [31:0] b_ir;

  int total = 0;
  int bad   = 0;

  instruction_fetch_register #(.BYTE_W(8), .BYTES(2), .LSB_FIRST(1), .SEL_W(2)) u_a (
    .i_clock(clk), .i_reset(rst), .i_i(a_i), .i_mode(a_mode), .i_write(a_write),
    .i_sel(a_sel), .i_start(a_start), .i_mem_rdy(a_mem_rdy), .i_ack(a_ack),
    .i_flush(a_flush), .o_mem_read(a_mem_read), .o_ir_valid(a_ir_valid),
    .o_busy(a_busy), .o_byte_cnt(a_cnt), .o_ir_out(a_ir)
  );

  instruction_fetch_register #(.BYTE_W(8), .BYTES(4), .LSB_FIRST(0)) u_b (
    .i_clock(clk), .i_reset(rst), .i_i(b_i), .i_mode(b_mode), .i_write(b_write),
    .i_sel(b_sel), .i_start(b_start), .i_mem_rdy(b_mem_rdy), .i_ack(b_ack),
    .i_flush(b_flush), .o_mem_read(b_mem_read), .o_ir_valid(b_ir_valid),
    .o_busy(b_busy), .o_byte_cnt(b_cnt), .o_ir_out(b_ir)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[%0t] %s observed=%h", $time, tag, obs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bytes4 [4];
    bytes4[0] = 8'h11; bytes4[1] = 8'h22; bytes4[2] = 8'h33; bytes4[3] = 8'h44;

    rst = 1'b1;
    a_i = '0; a_mode = 0; a_write = 0; a_sel = '0; a_start = 0; a_mem_rdy = 0; a_ack = 0; a_flush = 0;
    b_i = '0; b_mode = 0; b_write = 0; b_sel = '0; b_start = 0; b_mem_rdy = 0; b_ack = 0; b_flush = 0;
    tick(); tick();

    // Reset state
    chk("rst_a_ir", 32'(a_ir), 32'h0);
    chk("rst_a_flags", {29'd0, a_mem_read, a_ir_valid, a_busy}, 32'h0);
    chk("rst_a_cnt", 32'(a_cnt), 32'h0);
    chk("rst_b_ir", b_ir, 32'h0);
    chk("rst_b_flags", {29'd0, b_mem_read, b_ir_valid, b_busy}, 32'h0);
    #3 rst = 1'b0;
    tick();

    // Manual lane writes
    a_write = 1; a_sel = 2'd1; a_i = 8'hAB; tick();
    chk("man_lane1", 32'(a_ir), 32'h0000AB00);
    a_sel = 2'd0; a_i = 8'h12; tick();
    chk("man_lane0", 32'(a_ir), 32'h0000AB12);
    a_sel = 2'd2; a_i = 8'hFF; tick();
    chk("man_sel_oor", 32'(a_ir), 32'h0000AB12);
    a_write = 0;

    // Auto fetch, LSB first
    a_mode = 1; a_start = 1; tick();
    chk("af_enter_busy", {30'd0, a_mem_read, a_busy}, 32'h3);
    chk("af_enter_cnt", 32'(a_cnt), 32'h0);
    a_start = 0; a_mem_rdy = 1; a_i = 8'h34; tick();
    chk("af_b0_ir", 32'(a_ir), 32'h0000AB34);
    chk("af_b0_cnt", 32'(a_cnt), 32'h1);
    chk("af_b0_valid", 32'(a_ir_valid), 32'h0);
    a_i = 8'h56; tick();
    a_mem_rdy = 0;
    chk("af_full_ir", 32'(a_ir), 32'h00005634);
    chk("af_full_valid", 32'(a_ir_valid), 32'h1);
    chk("af_full_cnt", 32'(a_cnt), 32'h2);
    chk("af_full_rd_busy", {30'd0, a_mem_read, a_busy}, 32'h0);

    // Start without Ack is ignored in FULL
    a_start = 1; a_mem_rdy = 1; a_i = 8'h99; tick();
    chk("full_start_noack", {31'd0, a_ir_valid}, 32'h1);
    chk("full_frozen_ir", 32'(a_ir), 32'h00005634);

    // Back-to-back: Ack and Start together
    a_mem_rdy = 0; a_ack = 1; a_start = 1; tick();
    a_ack = 0; a_start = 0;
    chk("b2b_valid_drop", 32'(a_ir_valid), 32'h0);
    chk("b2b_memread", 32'(a_mem_read), 32'h1);
    chk("b2b_cnt", 32'(a_cnt), 32'h0);

    // Write and Mode changes during FETCH are ignored
    a_mode = 0; a_write = 1; a_sel = 2'd0; a_i = 8'h77; tick();
    chk("fetch_write_ign", 32'(a_ir), 32'h00005634);
    chk("fetch_mode_ign", 32'(a_busy), 32'h1);
    a_write = 0; a_mode = 1;
    a_mem_rdy = 1; a_i = 8'hEF; tick();
    a_i = 8'hBE; tick();
    a_mem_rdy = 0;
    chk("b2b_ir", 32'(a_ir), 32'h0000BEEF);
    chk("b2b_full", 32'(a_ir_valid), 32'h1);
    a_ack = 1; tick();
    a_ack = 0;
    chk("ack_idle_flags", {29'd0, a_mem_read, a_ir_valid, a_busy}, 32'h0);
    chk("ack_idle_cnt", 32'(a_cnt), 32'h0);

    // Flush after one byte, with MemRdy high in the flush cycle
    a_start = 1; tick();
    a_start = 0; a_mem_rdy = 1; a_i = 8'h99; tick();
    chk("flush_pre_cnt", 32'(a_cnt), 32'h1);
    a_flush = 1; a_i = 8'h88; tick();
    a_flush = 0; a_mem_rdy = 0;
    chk("flush_cnt", 32'(a_cnt), 32'h0);
    chk("flush_busy", 32'(a_busy), 32'h0);
    chk("flush_ir", 32'(a_ir), 32'h0000BE99);

    // Stall and MSB-first order on the 4-byte instance
    b_mode = 1; b_start = 1; tick();
    b_start = 0;
    for (int k = 0; k < 4; k++) begin
      b_i = bytes4[k]; b_mem_rdy = 1; tick();
      b_mem_rdy = 0;
      chk($sformatf("stall_cnt_b%0d", k), 32'(b_cnt), 32'(k + 1));
      if (k < 3) begin
        for (int s = 0; s < 2; s++) begin
          tick();
          chk($sformatf("stall_hold_b%0d_s%0d", k, s), {28'd0, b_cnt, b_mem_read}, {28'd0, 3'(k + 1), 1'b1});
        end
      end
      if (k == 0) chk("stall_first_lane", b_ir, 32'h11000000);
    end
    chk("stall_ir", b_ir, 32'h11223344);
    chk("stall_valid", 32'(b_ir_valid), 32'h1);
    b_ack = 1; tick();
    b_ack = 0;
    chk("stall_ack", 32'(b_ir_valid), 32'h0);

    // Asynchronous reset mid-fetch
    a_start = 1; tick();
    a_start = 0; a_mem_rdy = 1; a_i = 8'h42; tick();
    chk("ar_pre_ir", 32'(a_ir), 32'h0000BE42);
    #2 rst = 1'b1;
    #1;
    chk("ar_ir", 32'(a_ir), 32'h0);
    chk("ar_flags", {29'd0, a_mem_read, a_ir_valid, a_busy}, 32'h0);
    chk("ar_cnt", 32'(a_cnt), 32'h0);
    a_mem_rdy = 0;
    #2 rst = 1'b0;
    tick();
    chk("ar_idle", 32'(a_busy), 32'h0);
    a_start = 1; tick();
    a_start = 0; a_mem_rdy = 1; a_i = 8'h01; tick();
    a_i = 8'h02; tick();
    a_mem_rdy = 0;
    chk("ar_refetch_ir", 32'(a_ir), 32'h00000201);
    chk("ar_refetch_valid", 32'(a_ir_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
